ram_sync_be_init: RTL
=====================

// Module: ram_sync_be_init
// PURPOSE
//  Parametrised single-clock simple-dual-port synchronous RAM: one write port, one read port.
//  Adds byte-enable writes, read-enable with q_valid, write-first bypass and a post-reset clear sequencer.
//  Drop-in successor to the fixed 8x64 inferred RAM for packet buffers and lookup tables.
// PARAMETERS
//  DATA_W   16   data width in bits; must be a multiple of 8
//  ADDR_W   6    address width; DEPTH = 2**ADDR_W words
//  BE_W     DATA_W/8   byte-enable width (derived, do not override)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        synchronous active-low reset
//  we          in   1        write enable
//  be          in   BE_W     byte enables; be[i] gates data[8i+7:8i]
//  write_addr  in   ADDR_W   write address
//  data        in   DATA_W   write data
//  re          in   1        read enable
//  read_addr   in   ADDR_W   read address
//  q           out  DATA_W   read data
//  q_valid     out  1        q carries data for an accepted read
//  init_busy   out  1        clear sequence in progress; all ports ignored
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): q=0, q_valid=0, init_busy=1, clear pointer=0, FSM->CLEAR.
//  FSM: CLEAR -> READY. No other states.
//   CLEAR: one word per cycle, mem[ptr] <= 0, ptr++; after ptr=DEPTH-1 is written -> READY.
//   init_busy=1 for exactly DEPTH cycles after the rst_n rising edge, then 0.
//   READY: normal operation; stays until next reset.
//  Reset asserted mid-CLEAR restarts clear at ptr=0; no partial-state carry-over.
//  While init_busy=1: we and re ignored; q_valid=0; q holds 0.
//  Write (READY, we=1): for each i with be[i]=1, mem[write_addr] byte i <= data byte i.
//   Bytes with be[i]=0 keep old value. we=1 with be=0 is a legal no-op.
//  Read (READY, re=1): q <= mem[read_addr] at the same posedge; q_valid=1 the following cycle.
//   Read latency 1 cycle (see CONFIGURATION). re=0: q holds last value, q_valid=0.
//  Same-cycle read and write, same address: write-first. q returns merged word:
//   enabled bytes from data, disabled bytes from old mem contents.
//  Same-cycle read and write, different address: independent, no interaction.
//  Addresses wrap naturally; no out-of-range condition exists (DEPTH = 2**ADDR_W).
//  q_valid is a pure registered copy of (re & ~init_busy), aligned with q.
// CONFIGURATION
//  RAM_OUT_REG_EN defined: extra output register after the array read.
//   Read latency 2 cycles; q and q_valid both delayed one more cycle, still aligned.
//   Output register resets to 0; updates only when its stage-1 valid is 1, else holds.
//   Bypass still applies at the array read stage (stage 1).
//  RAM_OUT_REG_EN undefined: latency 1 as above; no extra flops.
// TESTING  (defaults DATA_W=16, ADDR_W=6)
//  Reset 3 cycles, release -> init_busy=1 for 64 cycles then 0; read every addr 0..63 -> q=16'h0000.
//  we=1 be=2'b11 addr 5 data 16'hA55A; next cycle re=1 addr 5 -> q=16'hA55A, q_valid=1 one cycle later (2 with RAM_OUT_REG_EN).
//  Write addr 7 16'h1234 be=11; then be=2'b01 data 16'hFFCC -> read addr 7 gives 16'h12CC.
//  Same cycle we=1 be=2'b10 addr 9 data 16'hBE00, re=1 addr 9 (old 16'h0011) -> q=16'hBE11.
//  Assert rst_n=0 at clear ptr 20, release -> init_busy=1 for full 64 cycles; writes during busy do not land.
//  re=0 after read of 16'hA55A -> q holds 16'hA55A, q_valid=0; write addr 63 then read 63 -> correct, no wrap aliasing with addr 0.

Source files
------------

// File: rtl/ram_sync_be_init.sv
// Simple-dual-port synchronous RAM: byte-enable writes, write-first bypass, post-reset clear sequencer.
// Optional macro RAM_OUT_REG_EN adds an output register (read latency 2 instead of 1).
module ram_sync_be_init #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] data,
    input  logic              re,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              init_busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              rd_en;
    logic              hit;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] s1_q;
    logic              s1_valid;

    assign wr_en = (state == READY) && we;
    assign rd_en = (state == READY) && re;
    assign hit   = wr_en && (write_addr == read_addr);

    // Write-first: enabled bytes of a colliding write replace the stored bytes on the read path.
    always_comb begin
        rd_word = mem[read_addr];
        for (int i = 0; i < BE_W; i++) begin
            if (hit && be[i]) begin
                rd_word[8*i +: 8] = data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                state     <= READY;
                init_busy <= 1'b0;
            end
        end
    end

    // NOTE: the array has no reset branch; the clear sequencer zeroes it so it still maps onto RAM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[write_addr][8*i +: 8] <= data[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_q <= rd_word;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= s1_valid;
            if (s1_valid) begin
                q <= s1_q;
            end
        end
    end
`else
    assign q       = s1_q;
    assign q_valid = s1_valid;
`endif

endmodule
